idct_8x8_seq: RTL
=================

Name: idct_8x8_seq

Overview:
- Sequential 8x8 two-dimensional inverse DCT: X = T^T * Y * T, then level shift +128 and clamp to 8-bit pixels.
- Y is the signed coefficient block. T is the integer-scaled DCT basis, t*SCALE rounded.
- Sits after the forward DCT/quantiser path and restores the pixel block for display or comparison.
- Uses one multiply-divide-accumulate per clock. Start/busy/done handshake.

Parameters:
- N, 8, matrix dimension; the only supported value.
- ELEM_W, 16, signed width of coefficient, basis and intermediate elements.
- SCALE, 10000, fixed-point scale of T; every product is divided by SCALE.
- LEVEL, 128, level shift added to the final result.

Ports:
- Clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  request; sampled only in IDLE.
- Y_in  in  1024  coefficients; element (i,j) at bits (i*8+j)*16 +:16, signed.
- T_in  in  1024  basis matrix, same packing, signed.
- busy  out  1  high from the cycle after start is accepted until done is asserted.
- done  out  1  one-cycle pulse; P_out is valid from this cycle onward.
- P_out  out  512  pixels; pixel (i,j) at bits (i*8+j)*8 +:8, unsigned.

Behaviour:
- Reset: state IDLE; busy=0, done=0, P_out=0; all internal matrices, indices and accumulators cleared.
- Reset mid-operation aborts immediately. No done is produced for the aborted block.
- States and transitions:
  - IDLE -> LOAD: on start=1. Y_in and T_in are captured at this edge (E0); later input changes are ignored.
  - LOAD -> PASS1: clears the Tmp matrix and i, j, k.
  - PASS1: Tmp[i][j] += sat16(trunc((T[k][i]*Y[k][j]) / SCALE)). k is innermost, then j, then i; one product per clock; 512 cycles.
  - PASS1 -> PASS2: at i=j=k=7. Clears the X accumulators.
  - PASS2: X[i][j] += trunc((Tmp[i][k]*T[k][j]) / SCALE). Same loop order; 512 cycles.
  - PASS2 -> FINISH: at i=j=k=7.
  - FINISH: P_out[i][j] = clamp(X[i][j] + LEVEL, 0, 255) for all 64 elements; done=1 for this one cycle; then -> IDLE.
- Arithmetic and width rules:
  - Products are 32-bit signed.
  - Division is signed and truncates toward zero.
  - PASS1 accumulation saturates at +32767/-32768 (no wrap).
  - PASS2 accumulators are 24-bit signed and clamped only at the final clamp.
- Latency: start sampled at edge E0; done is high in the cycle following edge E0+1026. Fixed 1027-cycle period from start to IDLE.
- busy is high in LOAD, PASS1, PASS2 and FINISH; low in IDLE.
- start while busy, including the FINISH/done cycle: ignored, not queued.
- P_out holds its last value until the next FINISH or reset. It does not change at a new start.
- start held high continuously: a new block is accepted on the first IDLE cycle, giving back-to-back operation with a 1-cycle IDLE gap.

Decomposition:
- Package idct_pkg holds:
  - constants N, ELEM_W, SCALE, LEVEL, PIX_W=8;
  - state enum {IDLE, LOAD, PASS1, PASS2, FINISH};
  - functions sat16 and clamp8;
  - index-to-bit-offset helpers for the 16-bit and 8-bit packings.
- Sub-module idct_mac (combinational): operands a, b, acc_in and mode (sat16 vs. wide); output acc_out = acc_in + trunc(a*b/SCALE). Shared by both passes.
- Top level contains the FSM, i/j/k counters and matrix storage.

Test Plan:
- Identity basis, Y=0: T[i][i]=10000, all else 0; Y all 0 -> done after 1027 cycles; all 64 pixels = 128; busy low afterward.
- Identity basis, signed values: Y[3][5]=300, Y[0][0]=-300, Y[7][7]=50 -> P(3,5)=255, P(0,0)=0, P(7,7)=178; others 128.
- Real DCT basis, DC only: T row 0 = 3536, other rows = standard rounded cosines; Y[0][0]=800, rest 0 -> every pixel = 227 (Tmp column 0 = 282).
- start pulsed at cycle 200 of PASS1, and again during the done cycle -> both ignored; exactly one done pulse.
- Reset asserted asynchronously mid-PASS2 (between clock edges) -> busy=0, done=0, P_out=0 immediately; a following start with the identity/Y=0 stimulus yields all pixels 128.
- start held high across two blocks: second block has identity T, Y[1][1]=20 -> two done pulses 1028 cycles apart; second P(1,1)=148.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the sequential 8x8 IDCT.
// Both packed buses are row-major: element (i,j) sits at flat index i*N+j.
package idct_pkg;
   localparam int N      = 8;
   localparam int ELEM_W = 16;
   localparam int SCALE  = 10000;
   localparam int LEVEL  = 128;
   localparam int PIX_W  = 8;
   localparam int ACC_W  = 24;

   typedef enum logic [2:0] {IDLE, LOAD, PASS1, PASS2, FINISH} state_t;

   function automatic logic signed [ELEM_W-1:0] sat16(input logic signed [31:0] v);
      if (v > 32'sd32767) return 16'sh7fff;
      else if (v < -32'sd32768) return 16'sh8000;
      else return v[ELEM_W-1:0];
   endfunction

   function automatic logic [PIX_W-1:0] clamp8(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W:0] s;
      s = (ACC_W+1)'(v) + (ACC_W+1)'(LEVEL);
      if (s < 0) return 8'd0;
      else if (s > 255) return 8'd255;
      else return s[PIX_W-1:0];
   endfunction

   function automatic int off16(input int i, input int j);
      return (i*N + j) * ELEM_W;
   endfunction

   function automatic int off8(input int i, input int j);
      return (i*N + j) * PIX_W;
   endfunction
endpackage

// File: rtl/idct_8x8_seq_if.sv
// Start/busy/done handshake plus the packed coefficient, basis and pixel buses.
interface idct_8x8_seq_if;
   import idct_pkg::*;
   logic                        start;
   logic [N*N*ELEM_W-1:0]       Y_in;
   logic [N*N*ELEM_W-1:0]       T_in;
   logic                        busy;
   logic                        done;
   logic [N*N*PIX_W-1:0]        P_out;

   modport master (output start, Y_in, T_in, input busy, done, P_out);
   modport slave  (input start, Y_in, T_in, output busy, done, P_out);
endinterface

// File: rtl/idct_mac.sv
// Combinational multiply-divide-accumulate shared by both IDCT passes.
// sat_mode_i selects the saturating 16-bit accumulation; otherwise the 24-bit sum wraps.
module idct_mac
   import idct_pkg::*;
(
   input  logic signed [ELEM_W-1:0] a_i,
   input  logic signed [ELEM_W-1:0] b_i,
   input  logic signed [ACC_W-1:0]  acc_i,
   input  logic                     sat_mode_i,
   output logic signed [ACC_W-1:0]  acc_o
);
   logic signed [31:0] prod;
   logic signed [31:0] quot;
   logic signed [31:0] sum;

   always_comb begin
      prod = 32'(a_i) * 32'(b_i);
      quot = prod / SCALE;
      sum  = '0;
      if (sat_mode_i) begin
         sum   = 32'(acc_i) + 32'(sat16(quot));
         acc_o = ACC_W'(sat16(sum));
      end else begin
         sum   = 32'(acc_i) + quot;
         acc_o = sum[ACC_W-1:0];
      end
   end
endmodule

// File: rtl/idct_8x8_seq.sv
// Sequential 8x8 IDCT: Tmp = T^T*Y, then X = Tmp*T, one MAC per clock, then level shift and clamp.
// PASS2 spends one extra drain cycle after its last product so P_out is registered before done.
module idct_8x8_seq
   import idct_pkg::*;
(
   input  logic Clock,
   input  logic reset,
   idct_8x8_seq_if.slave bus
);
   state_t state_q, state_d;
   logic [8:0]               idx_q;
   logic                     last_q;
   logic signed [ELEM_W-1:0] y_q   [N][N];
   logic signed [ELEM_W-1:0] t_q   [N][N];
   logic signed [ELEM_W-1:0] tmp_q [N][N];
   logic signed [ACC_W-1:0]  x_q   [N][N];
   logic [N*N*PIX_W-1:0]     p_out_q;
   logic                     busy, done;

   logic [2:0] i_idx, j_idx, k_idx;
   logic signed [ELEM_W-1:0] mac_a, mac_b;
   logic signed [ACC_W-1:0]  mac_acc_in, mac_acc_out;
   logic                     mac_sat;

   // Loop order is k innermost, then j, then i.
   assign i_idx = idx_q[8:6];
   assign j_idx = idx_q[5:3];
   assign k_idx = idx_q[2:0];

   always_comb begin
      mac_a      = tmp_q[i_idx][k_idx];
      mac_b      = t_q[k_idx][j_idx];
      mac_acc_in = x_q[i_idx][j_idx];
      mac_sat    = 1'b0;
      if (state_q == PASS1) begin
         mac_a      = t_q[k_idx][i_idx];
         mac_b      = y_q[k_idx][j_idx];
         mac_acc_in = ACC_W'(tmp_q[i_idx][j_idx]);
         mac_sat    = 1'b1;
      end
   end

   idct_mac u_mac (
      .a_i        (mac_a),
      .b_i        (mac_b),
      .acc_i      (mac_acc_in),
      .sat_mode_i (mac_sat),
      .acc_o      (mac_acc_out)
   );

   always_ff @(posedge Clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = LOAD;
         LOAD:    state_d = PASS1;
         PASS1:   if (idx_q == 9'd511) state_d = PASS2;
         PASS2:   if (last_q) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == FINISH);
   end

   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         idx_q   <= '0;
         last_q  <= 1'b0;
         p_out_q <= '0;
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               y_q[r][c]   <= '0;
               t_q[r][c]   <= '0;
               tmp_q[r][c] <= '0;
               x_q[r][c]   <= '0;
            end
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  for (int r = 0; r < N; r++) begin
                     for (int c = 0; c < N; c++) begin
                        y_q[r][c] <= bus.Y_in[off16(r, c) +: ELEM_W];
                        t_q[r][c] <= bus.T_in[off16(r, c) +: ELEM_W];
                     end
                  end
               end
            end
            LOAD: begin
               idx_q  <= '0;
               last_q <= 1'b0;
               for (int r = 0; r < N; r++) begin
                  for (int c = 0; c < N; c++) tmp_q[r][c] <= '0;
               end
            end
            PASS1: begin
               tmp_q[i_idx][j_idx] <= mac_acc_out[ELEM_W-1:0];
               idx_q <= idx_q + 9'd1;
               if (idx_q == 9'd511) begin
                  for (int r = 0; r < N; r++) begin
                     for (int c = 0; c < N; c++) x_q[r][c] <= '0;
                  end
               end
            end
            PASS2: begin
               if (!last_q) begin
                  x_q[i_idx][j_idx] <= mac_acc_out;
                  idx_q <= idx_q + 9'd1;
                  if (idx_q == 9'd511) last_q <= 1'b1;
               end else begin
                  last_q <= 1'b0;
                  for (int r = 0; r < N; r++) begin
                     for (int c = 0; c < N; c++) p_out_q[off8(r, c) +: PIX_W] <= clamp8(x_q[r][c]);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy  = busy;
   assign bus.done  = done;
   assign bus.P_out = p_out_q;
endmodule
